// File: rtl/wb_ram_arbiter.sv
// Three-master round-robin Wishbone arbiter in front of a single RAM slave.
// Optional stall watchdog: define WB_ARB_WATCHDOG_EN to error-terminate a hung slave cycle.
module wb_ram_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [2:0]        m_cyc_i,
   input  logic [2:0]        m_stb_i,
   input  logic [2:0]        m_we_i,
   input  logic [11:0]       m_sel_i,
   input  logic [3*AW-1:0]   m_adr_i,
   input  logic [3*DW-1:0]   m_dat_i,
   output logic [DW-1:0]     m_dat_o,
   output logic [2:0]        m_ack_o,
   output logic [2:0]        m_err_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [3:0]        s_sel_o,
   output logic [AW-1:0]     s_adr_o,
   output logic [DW-1:0]     s_dat_o,
   input  logic [DW-1:0]     s_dat_i,
   input  logic              s_ack_i,
   input  logic              s_err_i,
   output logic [2:0]        grant_o
);

   localparam int NM = 3;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state_q, state_d;
   logic [NM-1:0] grant_q, grant_d;
   logic [1:0]    last_q, last_d;
   logic [1:0]    pick;
   logic          pick_vld;
   logic          owner_cyc;
   logic          wd_hit;

   // Search starts one past the most recent owner so every requester gets a turn.
   always_comb begin
      pick_vld = 1'b0;
      pick     = last_q;
      for (int k = 1; k <= NM; k++) begin
         if (!pick_vld && m_cyc_i[(int'(last_q) + k) % NM]) begin
            pick_vld = 1'b1;
            pick     = 2'((int'(last_q) + k) % NM);
         end
      end
   end

   // One-hot AND-OR mux; grant_q is zero in IDLE so every slave-side output is zero there.
   always_comb begin
      owner_cyc = 1'b0;
      s_stb_o   = 1'b0;
      s_we_o    = 1'b0;
      s_sel_o   = '0;
      s_adr_o   = '0;
      s_dat_o   = '0;
      for (int i = 0; i < NM; i++) begin
         if (grant_q[i]) begin
            owner_cyc = owner_cyc | m_cyc_i[i];
            s_stb_o   = s_stb_o   | m_stb_i[i];
            s_we_o    = s_we_o    | m_we_i[i];
            s_sel_o   = s_sel_o   | m_sel_i[4*i +: 4];
            s_adr_o   = s_adr_o   | m_adr_i[AW*i +: AW];
            s_dat_o   = s_dat_o   | m_dat_i[DW*i +: DW];
         end
      end
   end

   assign s_cyc_o = owner_cyc;
   assign grant_o = grant_q;
   assign m_dat_o = s_dat_i;
   assign m_ack_o = grant_q & {NM{s_ack_i}};
   assign m_err_o = grant_q & {NM{s_err_i | wd_hit}};

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= 2'd2;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d = GRANT;
               grant_d = NM'(1) << pick;
               last_d  = pick;
            end
         end
         GRANT: begin
            // Owner keeps the bus across stb phases until it releases cyc.
            if (!owner_cyc) begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

`ifdef WB_ARB_WATCHDOG_EN
   localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [WD_W-1:0] wd_cnt_q;

   assign wd_hit = (state_q == GRANT) && (wd_cnt_q == WD_W'(TIMEOUT));

   // Held at zero in IDLE, so it starts from zero on entry to GRANT.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)                             wd_cnt_q <= '0;
      else if (state_q == IDLE)                 wd_cnt_q <= '0;
      else if (s_ack_i || s_err_i || wd_hit)    wd_cnt_q <= '0;
      else if (s_stb_o)                         wd_cnt_q <= wd_cnt_q + 1'b1;
   end
`else
   // No watchdog: this term is constant low, so errors come from the slave only.
   assign wd_hit = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Scoreboard bench for wb_ram_arbiter: directed accesses push expected grants/responses,
// a monitor pops and compares on every grant change and every ack/err.
module tb_wb_ram_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LIMIT = 500;

   logic            clk = 1'b0;
   logic            rst;
   logic [2:0]      m_cyc, m_stb, m_we;
   logic [11:0]     m_sel;
   logic [3*AW-1:0] m_adr;
   logic [3*DW-1:0] m_dat;
   logic [DW-1:0]   m_dat_o;
   logic [2:0]      m_ack_o, m_err_o;
   logic            s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]      s_sel_o;
   logic [AW-1:0]   s_adr_o;
   logic [DW-1:0]   s_dat_o;
   logic [DW-1:0]   s_rdat;
   logic            s_ack, s_err;
   logic [2:0]      grant_o;
   int              slave_mode;   // 0 never respond, 1 ack, 2 err

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] g;
      int         idle;
   } gexp_t;

   typedef struct {
      logic [2:0]    ack;
      logic [2:0]    err;
      logic [AW-1:0] adr;
      logic          we;
      logic [3:0]    sel;
      logic [DW-1:0] wd;
      logic [DW-1:0] rd;
   } rexp_t;

   gexp_t exp_g[$];
   rexp_t exp_r[$];

   wb_ram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .m_cyc_i  (m_cyc),
      .m_stb_i  (m_stb),
      .m_we_i   (m_we),
      .m_sel_i  (m_sel),
      .m_adr_i  (m_adr),
      .m_dat_i  (m_dat),
      .m_dat_o  (m_dat_o),
      .m_ack_o  (m_ack_o),
      .m_err_o  (m_err_o),
      .s_cyc_o  (s_cyc_o),
      .s_stb_o  (s_stb_o),
      .s_we_o   (s_we_o),
      .s_sel_o  (s_sel_o),
      .s_adr_o  (s_adr_o),
      .s_dat_o  (s_dat_o),
      .s_dat_i  (s_rdat),
      .s_ack_i  (s_ack),
      .s_err_i  (s_err),
      .grant_o  (grant_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] sel_of(input int m);
      case (m)
         0:       return 4'hF;
         1:       return 4'h3;
         default: return 4'hC;
      endcase
   endfunction

   task automatic push_g(input logic [2:0] g, input int idle);
      gexp_t e;
      e.g = g;
      e.idle = idle;
      exp_g.push_back(e);
   endtask

   task automatic push_r(input logic [2:0] ack, input logic [2:0] err, input logic [AW-1:0] adr,
                         input logic we, input int m, input logic [DW-1:0] wd, input logic [DW-1:0] rd);
      rexp_t e;
      e.ack = ack; e.err = err; e.adr = adr; e.we = we;
      e.sel = sel_of(m); e.wd = wd; e.rd = rd;
      exp_r.push_back(e);
   endtask

   // Slave: samples a fresh request at negedge, answers just after the following posedge.
   task automatic slave_loop();
      logic req;
      forever begin
         @(negedge clk);
         req = s_cyc_o && s_stb_o && !s_ack && !s_err;
         @(posedge clk);
         #1;
         s_ack = req && (slave_mode == 1);
         s_err = req && (slave_mode == 2);
      end
   endtask

   task automatic monitor_loop();
      logic [2:0] prev_g;
      int         idle_cnt;
      gexp_t      ge;
      rexp_t      re;
      prev_g = 3'b000;
      idle_cnt = 0;
      forever begin
         @(negedge clk);
         if (grant_o !== prev_g) begin
            if (exp_g.size() == 0) begin
               chk("grant_unexpected", {61'd0, grant_o}, {61'd0, prev_g});
            end else begin
               ge = exp_g.pop_front();
               chk("grant_seq", {61'd0, grant_o}, {61'd0, ge.g});
               if (ge.idle >= 0 && grant_o != 3'b000)
                  chk("idle_gap", 64'(idle_cnt), 64'(ge.idle));
            end
            prev_g = grant_o;
         end
         if (grant_o == 3'b000) idle_cnt++;
         else idle_cnt = 0;
         if ((m_ack_o | m_err_o) != 3'b000) begin
            if (exp_r.size() == 0) begin
               chk("rsp_unexpected", {58'd0, m_ack_o, m_err_o}, 64'd0);
            end else begin
               re = exp_r.pop_front();
               chk("rsp_ack", {61'd0, m_ack_o}, {61'd0, re.ack});
               chk("rsp_err", {61'd0, m_err_o}, {61'd0, re.err});
               chk("rsp_adr", {32'd0, s_adr_o}, {32'd0, re.adr});
               chk("rsp_we", {63'd0, s_we_o}, {63'd0, re.we});
               chk("rsp_sel", {60'd0, s_sel_o}, {60'd0, re.sel});
               chk("rsp_wdat", {32'd0, s_dat_o}, {32'd0, re.wd});
               chk("rsp_rdat", {32'd0, m_dat_o}, {32'd0, re.rd});
            end
         end
      end
   endtask

   // Drives one cycle of `beats` strobes (address steps by 4 per beat), then releases cyc.
   task automatic master_access(input int m, input int beats, input logic we,
                                input logic [AW-1:0] adr0, input logic [DW-1:0] wd);
      int n;
      logic [AW-1:0] adr;
      adr = adr0;
      m_we[m] = we;
      m_sel[4*m +: 4] = sel_of(m);
      m_adr[AW*m +: AW] = adr;
      m_dat[DW*m +: DW] = wd;
      m_cyc[m] = 1'b1;
      m_stb[m] = 1'b1;
      for (int b = 0; b < beats; b++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(m_ack_o[m] || m_err_o[m]) && n < LIMIT);
         chk($sformatf("m%0d_wait", m), 64'(n < LIMIT), 64'd1);
         @(posedge clk);
         #1;
         if (b == beats - 1) begin
            m_cyc[m] = 1'b0;
            m_stb[m] = 1'b0;
         end else begin
            adr = adr + 4;
            m_adr[AW*m +: AW] = adr;
         end
      end
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic err_seen;
      rst = 1'b1;
      m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
      s_ack = 1'b0; s_err = 1'b0;
      s_rdat = 32'hDEADBEEF;
      slave_mode = 1;
      fork
         monitor_loop();
         slave_loop();
      join_none

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", {61'd0, grant_o}, 64'd0);
      chk("rst_scyc", {63'd0, s_cyc_o}, 64'd0);
      chk("rst_sstb", {63'd0, s_stb_o}, 64'd0);
      chk("rst_ack", {61'd0, m_ack_o}, 64'd0);
      chk("rst_err", {61'd0, m_err_o}, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // single read by master 1
      push_g(3'b010, -1); push_g(3'b000, -1);
      push_r(3'b010, 3'b000, 32'h100, 1'b0, 1, 32'h0, 32'hDEADBEEF);
      fork
         master_access(1, 1, 1'b0, 32'h100, 32'h0);
         begin
            @(negedge clk);
            chk("arb_pre", {61'd0, grant_o}, 64'd0);
            @(negedge clk);
            chk("arb_latency", {61'd0, grant_o}, 64'b010);
         end
      join
      @(negedge clk);
      chk("cyc_follow", {63'd0, s_cyc_o}, 64'd0);
      @(negedge clk);
      chk("idle_after", {61'd0, grant_o}, 64'd0);
      chk("dat_passthru", {32'd0, m_dat_o}, 64'hDEADBEEF);
      settle();

      // all three request right after reset, one write each
      s_rdat = 32'h12345678;
      pulse_reset();
      push_g(3'b001, -1); push_g(3'b000, -1);
      push_g(3'b010, 1);  push_g(3'b000, -1);
      push_g(3'b100, 1);  push_g(3'b000, -1);
      push_r(3'b001, 3'b000, 32'h10, 1'b1, 0, 32'hA0, 32'h12345678);
      push_r(3'b010, 3'b000, 32'h20, 1'b1, 1, 32'hA1, 32'h12345678);
      push_r(3'b100, 3'b000, 32'h30, 1'b1, 2, 32'hA2, 32'h12345678);
      fork
         master_access(0, 1, 1'b1, 32'h10, 32'hA0);
         master_access(1, 1, 1'b1, 32'h20, 32'hA1);
         master_access(2, 1, 1'b1, 32'h30, 32'hA2);
      join
      settle();

      // master 0 holds for 4 beats while 1 and 2 wait
      push_g(3'b001, -1); push_g(3'b000, -1);
      push_g(3'b010, 1);  push_g(3'b000, -1);
      push_g(3'b100, 1);  push_g(3'b000, -1);
      for (int b = 0; b < 4; b++)
         push_r(3'b001, 3'b000, 32'h40 + 32'(4*b), 1'b0, 0, 32'hB0, 32'h12345678);
      push_r(3'b010, 3'b000, 32'h50, 1'b1, 1, 32'hB1, 32'h12345678);
      push_r(3'b100, 3'b000, 32'h60, 1'b1, 2, 32'hB2, 32'h12345678);
      fork
         master_access(0, 4, 1'b0, 32'h40, 32'hB0);
         master_access(1, 1, 1'b1, 32'h50, 32'hB1);
         master_access(2, 1, 1'b1, 32'h60, 32'hB2);
      join
      settle();

      // reset while master 2 owns a stalled cycle
      slave_mode = 0;
      push_g(3'b100, -1); push_g(3'b000, -1);
      push_g(3'b001, -1); push_g(3'b000, -1);
      m_sel = 12'hC3F; m_we = 3'b000;
      m_adr[AW*2 +: AW] = 32'h70;
      m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
      repeat (2) @(negedge clk);
      chk("d_owner", {61'd0, grant_o}, 64'b100);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      m_cyc = 3'b111; m_stb = 3'b111;
      @(negedge clk);
      chk("midrst_grant", {61'd0, grant_o}, 64'd0);
      chk("midrst_scyc", {63'd0, s_cyc_o}, 64'd0);
      @(negedge clk);
      chk("midrst_first", {61'd0, grant_o}, 64'b001);
      @(posedge clk);
      #1 m_cyc = 3'b000; m_stb = 3'b000;
      settle();

      // slave error on master 2
      slave_mode = 2;
      push_g(3'b100, -1); push_g(3'b000, -1);
      push_r(3'b000, 3'b100, 32'h80, 1'b1, 2, 32'hE2, 32'h12345678);
      master_access(2, 1, 1'b1, 32'h80, 32'hE2);
      settle();

      // stalled slave on master 0
      slave_mode = 0;
      push_g(3'b001, -1); push_g(3'b000, -1);
`ifdef WB_ARB_WATCHDOG_EN
      push_r(3'b000, 3'b001, 32'h90, 1'b0, 0, 32'h0, 32'h12345678);
      fork
         master_access(0, 1, 1'b0, 32'h90, 32'h0);
         begin
            n = 0;
            while (grant_o !== 3'b001 && n < 20) begin
               @(negedge clk);
               n++;
            end
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (m_err_o == 3'b000 && n < 50);
            chk("wd_latency", 64'(n), 64'd8);
            @(negedge clk);
            chk("wd_pulse_width", {61'd0, m_err_o}, 64'd0);
         end
      join
`else
      m_adr[0 +: AW] = 32'h90;
      m_we[0] = 1'b0;
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      err_seen = 1'b0;
      repeat (1000) begin
         @(negedge clk);
         if (m_err_o != 3'b000) err_seen = 1'b1;
      end
      chk("no_wd_err", {63'd0, err_seen}, 64'd0);
      chk("stall_grant_held", {61'd0, grant_o}, 64'b001);
      @(posedge clk);
      #1 m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
`endif
      settle();

      chk("grant_queue_empty", 64'(exp_g.size()), 64'd0);
      chk("rsp_queue_empty", 64'(exp_r.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_ram_arbiter.md
WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter TIMEOUT, default 255: watchdog limit in cycles (used only under REQ-032).
REQ-004 wb_clk_i  in  1  clock. All logic is on the rising edge.
REQ-005 wb_rst_i  in  1  reset. It is synchronous and active-high.
REQ-006 m_cyc_i  in  3  master cycle requests. Bit 0 = instruction bus, bit 1 = data bus, bit 2 = debug/JTAG.
REQ-007 m_stb_i, m_we_i  in  3 each  per-master strobe and write enable.
REQ-008 m_sel_i  in  12  per-master byte selects, packed 4 bits per master, master 0 in the LSBs.
REQ-009 m_adr_i  in  3*AW  packed per-master address.
REQ-010 m_dat_i  in  3*DW  packed per-master write data.
REQ-011 m_dat_o  out  DW  read data, broadcast to all masters.
REQ-012 m_ack_o, m_err_o  out  3 each  per-master acknowledge and error.
REQ-013 s_cyc_o, s_stb_o, s_we_o  out  1 each  RAM slave control.
REQ-014 s_sel_o  out  4; s_adr_o  out  AW; s_dat_o  out  DW  signals to the RAM slave.
REQ-015 s_dat_i  in  DW; s_ack_i, s_err_i  in  1 each  RAM slave responses.
REQ-016 grant_o  out  3  one-hot registered owner; all zero when idle.

Function
REQ-017 The FSM has exactly two states, IDLE and GRANT.
REQ-018 In IDLE:
- grant_o = 0;
- s_cyc_o, s_stb_o, m_ack_o and m_err_o are all 0.
REQ-019 In IDLE with any m_cyc_i bit set, the arbiter registers a one-hot grant and enters GRANT on the next edge. Arbitration latency is 1 cycle.
REQ-020 Selection is round-robin. Search order starts at (last+1) mod 3, where last is the index of the most recent owner.
REQ-021 last is updated when the grant is registered.
REQ-022 In GRANT, the owner's cyc, stb, we, sel, adr and dat are combinationally muxed onto s_*_o.
REQ-023 In GRANT, s_ack_i and s_err_i are routed only to the owner's m_ack_o and m_err_o bits. All other bits are 0.
REQ-024 m_dat_o = s_dat_i at all times.
REQ-025 Ownership is held for the whole cycle, including multiple stb phases, until the owner deasserts m_cyc_i.
REQ-026 Requests from other masters never preempt the owner.
REQ-027 When the owner's m_cyc_i is low in GRANT, the FSM returns to IDLE on the next edge.
- s_cyc_o follows the owner's cyc, so it is 0 in that same cycle.
- There is at least one IDLE cycle between consecutive owners.
REQ-028 A master that drops m_cyc_i while not granted loses nothing. It stores no pending state.
REQ-029 When all three masters request simultaneously after reset, the grant order is 0, 1, 2, 0, ...
REQ-030 With a single persistent requester, that master is re-granted after each IDLE cycle.

Reset
REQ-031 When wb_rst_i is high at an edge, the next state is:
- FSM in IDLE, grant_o = 0, last = 2;
- watchdog counter = 0;
- all outputs derived from the grant are 0.
This applies even in the middle of a GRANT; any in-progress slave cycle is abandoned.

Configuration
REQ-032 When WB_ARB_WATCHDOG_EN is defined, an 8-bit+ counter is added:
- it clears on entry to GRANT and on any s_ack_i or s_err_i;
- it increments each GRANT cycle in which s_stb_o=1 and neither response is present.
REQ-033 When the counter reaches TIMEOUT, the watchdog does the following:
- m_err_o for the owner is asserted for exactly one cycle;
- the counter clears;
- the grant is held until the owner drops m_cyc_i.
REQ-034 When WB_ARB_WATCHDOG_EN is not defined, no counter is implemented. GRANT waits indefinitely, and m_err_o reflects only s_err_i.

Verification
REQ-035 Reset then single read: master 1 drives cyc/stb with adr=0x100, and the slave acks 1 cycle later with dat=0xDEADBEEF. Required response:
- grant_o=3'b010 one cycle after the request;
- m_ack_o=3'b010 with m_dat_o=0xDEADBEEF;
- IDLE after cyc drops.
REQ-036 All three masters request from the first cycle after reset, each doing one single-beat write. Grants are 001, 010, 100, with exactly one IDLE cycle between each.
REQ-037 Master 0 holds cyc for 4 acked beats while masters 1 and 2 request. Required response:
- grant_o stays 001 for all 4 beats;
- m_ack_o bits 1 and 2 are never set;
- master 1 is granted next.
REQ-038 Assert wb_rst_i for 1 cycle mid-GRANT while master 2 owns the bus. On the next edge grant_o=0 and s_cyc_o=0, and with all masters then requesting, master 0 is granted first.
REQ-039 With WB_ARB_WATCHDOG_EN and TIMEOUT=8, the slave never acks master 0's strobe. m_err_o=3'b001 pulses for one cycle after 8 stalled cycles. Without the macro, no err occurs within 1000 cycles.
REQ-040 The slave asserts s_err_i for master 2's access. Required response: m_err_o=3'b100 in the same cycle and m_ack_o=0.
